// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic constants and FSM state encoding
package arith_pkg;

  // Operand width shared by the ripple adder and the serial subtractor.
  localparam int DEFAULT_WIDTH = 4;

  // Serial subtractor control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - combinational 1-bit full subtractor cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated when a < b + bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - bin with start/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             bout,
  output logic [WIDTH-1:0] diff
);

  // One extra bit so WIDTH = 1 still has a representable counter.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] d_sr_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             bit_d;
  logic             brw_d;
  logic [WIDTH-1:0] d_sr_d;

  // Single bit cell operating on the current LSBs and the registered borrow.
  full_subtractor u_cell (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .bin  (brw_q),
    .d    (bit_d),
    .bout (brw_d)
  );

  // New difference bit enters at the MSB so the LSB-first result lands in place.
  always_comb begin
    d_sr_d = WIDTH'({bit_d, d_sr_q} >> 1);
  end

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      d_sr_q  <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_sr_q  <= A;
            b_sr_q  <= B;
            brw_q   <= bin;
            cnt_q   <= '0;
            d_sr_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          brw_q  <= brw_d;
          d_sr_q <= d_sr_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            // Publish the completed result together with the done pulse.
            diff_q  <= d_sr_d;
            bout_q  <= brw_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bout = bout_q;
  assign diff = diff_q;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Bit-serial, multi-cycle subtractor. Computes `A - B - bin` one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow.
- It is the inverse-direction companion to the 4-bit ripple-carry adder and is sized to match it by default (WIDTH = 4).
- It trades area for latency and exposes a start/done handshake, so it can be driven by control logic rather than purely combinational stimulus.

## Interface

Parameters:
- `WIDTH`, default 4: operand and difference width in bits (must be ≥ 1).

Ports:
- `clk` (input, 1): single clock; all state updates on its rising edge.
- `rst` (input, 1): reset, synchronous, active-high.
- `start` (input, 1): request a new operation; sampled only in IDLE.
- `bin` (input, 1): borrow-in; captured with `start`.
- `A` (input, WIDTH): minuend; captured with `start`.
- `B` (input, WIDTH): subtrahend; captured with `start`.
- `busy` (output, 1): high while an operation is in progress (state SHIFT).
- `done` (output, 1): one-cycle pulse when `diff`/`bout` become valid.
- `bout` (output, 1): borrow-out of the last operation; registered.
- `diff` (output, WIDTH): difference of the last operation; registered.

## Operation

- **States:** IDLE, SHIFT, DONE.
- **IDLE**
  - On `start == 1`: load shift registers `a_sr <= A`, `b_sr <= B`, `brw <= bin`, `cnt <= 0`, `d_sr <= 0`; go to SHIFT.
  - Otherwise hold.
- **SHIFT**, each cycle:
  - Bit difference: `d = a_sr[0] ^ b_sr[0] ^ brw`.
  - Next borrow: `brw_n = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw)`.
  - Shift `a_sr` and `b_sr` right by one.
  - Shift `d` into the MSB of `d_sr`.
  - `cnt <= cnt + 1`.
  - When `cnt == WIDTH-1`, go to DONE.
- **DONE**
  - `diff <= d_sr`, `bout <= brw`, `done = 1` for this cycle only.
  - Return to IDLE next cycle.
- **Arithmetic:** result equals `(A - B - bin) mod 2^WIDTH`; `bout = 1` iff `A < B + bin` (unsigned).
- **Output holding:** `diff`/`bout` are visible only after DONE and hold their value until the next DONE; intermediate shifting is never visible on the outputs.
- **`start` while busy:** `start` in SHIFT or DONE is ignored. No queuing, and captured operands are unaffected by later changes on `A`/`B`/`bin`.
- **Reset:**
  - All outputs and state reset on `rst == 1` at a clock edge: `busy = 0`, `done = 0`, `bout = 0`, `diff = 0`, state = IDLE, `cnt = 0`, `brw = 0`.
  - A reset asserted mid-SHIFT aborts the operation; no `done` is produced.
- **Simultaneous `rst` and `start`:** reset wins.
- **`cnt` width:** `$clog2(WIDTH)+1` bits so that WIDTH = 1 works; WIDTH = 1 runs one SHIFT cycle.

## Timing

- Cycle 0: `start` sampled high in IDLE.
- Cycles 1..WIDTH: SHIFT, `busy = 1`.
- Cycle WIDTH+1: DONE, `done = 1`, new `diff`/`bout` valid from this cycle on.
- Total latency from the `start` edge to `done` is WIDTH+1 cycles (5 for WIDTH = 4).
- Earliest next accepted `start` is cycle WIDTH+2, giving an issue interval of WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- **Package `arith_pkg`:**
  - 2-bit state encoding constants `ST_IDLE = 0`, `ST_SHIFT = 1`, `ST_DONE = 2`.
  - The default-width constant, shared with the adder blocks.
- **Sub-module `full_subtractor`:**
  - Ports: `a`, `b`, `bin` → `d`, `bout`.
  - Combinational; one instance in the datapath.
  - Reused as the bit cell of any future ripple subtractor.
- **Top level:** FSM, counter, three shift registers and output registers.

## Test plan

- **Basic subtract:** `A=9`, `B=3`, `bin=0`, pulse `start` → after 5 cycles `done=1`, `diff=6`, `bout=0`; `busy` high exactly cycles 1–4.
- **Underflow:** `A=3`, `B=9`, `bin=0` → `diff=4'hA`, `bout=1`. With `A=0`, `B=0`, `bin=1` → `diff=4'hF`, `bout=1`.
- **Exhaustive:** loop `A` 0..15, `B` 0..15, `bin` 0..1, waiting for `done` each time. Compare against `{bout,diff} == ({1'b0,A} - B - bin)` (5-bit result); 512 checks, zero mismatches.
- **Ignored start:** start `A=15`, `B=1`; re-pulse `start` with `A=0`, `B=5` during SHIFT → result `diff=14`, `bout=0`, only one `done` pulse.
- **Reset mid-op:** assert `rst` in the 2nd SHIFT cycle → next cycle `busy=0`, `diff=0`, `bout=0`, and no `done` ever appears for that operation. A new `start` afterwards completes normally.
- **Param sweep:** WIDTH=1 (`A=0`, `B=1` → `diff=1`, `bout=1`, latency 2) and WIDTH=8 (`A=8'h80`, `B=8'h01` → `diff=8'h7F`, `bout=0`, latency 9).
